// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Wide enough for any supported D; the top slices its own width
    localparam logic [63:0] DIVZ_LO = {64{1'b1}};

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module muldiv_step #(
    parameter int D = 32
) (
    input  logic         is_div_i,
    input  logic [D-1:0] acc_i,
    input  logic [D-1:0] lo_i,
    input  logic [D-1:0] b_i,
    output logic [D-1:0] acc_o,
    output logic [D-1:0] lo_o
);

    logic [D:0] sum;
    logic [D:0] rem_sh;
    logic       fits;

    always_comb begin
        sum    = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        rem_sh = {acc_i, lo_i[D-1]};
        fits   = (rem_sh >= {1'b0, b_i});
        acc_o  = sum[D:1];
        lo_o   = {sum[0], lo_i[D-1:1]};
        if (is_div_i) begin
            // The difference is below the divisor, so it always fits in D bits
            if (fits) begin
                acc_o = D'(rem_sh - {1'b0, b_i});
                lo_o  = {lo_i[D-2:0], 1'b1};
            end else begin
                acc_o = rem_sh[D-1:0];
                lo_o  = {lo_i[D-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU with HI/LO; MULDIV_FAST_MUL_EN selects one-cycle multiply
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int D = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [D-1:0] rs_data,
    input  logic [D-1:0] rt_data,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [D-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [D-1:0] hi,
    output logic [D-1:0] lo
);

    localparam logic [5:0] CNT_LAST = 6'(D - 1);

    state_e         state_q, state_d;
    logic           div_q, div_d;
    logic           neg_lo_q, neg_lo_d;
    logic           neg_hi_q, neg_hi_d;
    logic           divz_q, divz_d;
    logic           done_q, done_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [D-1:0]   acc_q, acc_d;
    logic [D-1:0]   lo_acc_q, lo_acc_d;
    logic [D-1:0]   b_q, b_d;
    logic [D-1:0]   hi_q, hi_d;
    logic [D-1:0]   lo_q, lo_d;

    logic           a_neg, b_neg;
    logic [D-1:0]   a_mag, b_mag;
    logic [D-1:0]   step_acc, step_lo;
    logic [2*D-1:0] prod_raw, prod_fix;
    logic [D-1:0]   quot, rem;

    muldiv_step #(.D(D)) u_step (
        .is_div_i (div_q),
        .acc_i    (acc_q),
        .lo_i     (lo_acc_q),
        .b_i      (b_q),
        .acc_o    (step_acc),
        .lo_o     (step_lo)
    );

    always_comb begin
        a_neg = is_signed_op(op) && rs_data[D-1];
        b_neg = is_signed_op(op) && rt_data[D-1];
        a_mag = a_neg ? -rs_data : rs_data;
        b_mag = b_neg ? -rt_data : rt_data;
    end

    // Magnitude results are corrected here; divide-by-zero leaves |rs| in acc, so the
    // dividend-sign fixup on HI reproduces rs exactly
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_raw = {{D{1'b0}}, lo_acc_q} * {{D{1'b0}}, b_q};
`else
        prod_raw = {acc_q, lo_acc_q};
`endif
        prod_fix = neg_lo_q ? -prod_raw : prod_raw;
        quot     = divz_q ? DIVZ_LO[D-1:0] : (neg_lo_q ? -lo_acc_q : lo_acc_q);
        rem      = neg_hi_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        divz_d   = divz_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_acc_d = lo_acc_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d    = op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    divz_d   = op[1] && (rt_data == '0);
                    acc_d    = '0;
                    lo_acc_d = a_mag;
                    b_d      = b_mag;
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef MULDIV_FAST_MUL_EN
                    if (!op[1]) state_d = FIX;
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                acc_d    = step_acc;
                lo_acc_d = step_lo;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            divz_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_acc_q <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            divz_q   <= divz_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_acc_q <= lo_acc_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data, wdata;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.D(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge with the unit idle; returns in the done cycle
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] h, output logic [31:0] l,
                          output logic bz);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        h = hi; l = lo; bz = busy;
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    endtask

    task automatic test_mult();
        int lat; logic [31:0] h, l; logic bz;
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, lat, h, l, bz);
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mult_latency got %0d exp %0d", lat, MUL_LAT); end
        checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", h); end
        checks++; if (l !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h exp ffffffeb", l); end
        checks++; if (bz !== 1'b0) begin errors++; $display("FAIL mult_busy_on_done got %b exp 0", bz); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_width got %b exp 0", done); end
        run_op(2'b00, 32'd6, 32'd7, lat, h, l, bz);
        checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mult6x7_latency got %0d exp %0d", lat, MUL_LAT); end
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL mult6x7_hi got %h exp 0", h); end
        checks++; if (l !== 32'd42) begin errors++; $display("FAIL mult6x7_lo got %h exp 2a", l); end
    endtask

    task automatic test_multu();
        int lat; logic [31:0] h, l; logic bz;
        @(posedge clk); #1;
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, h, l, bz);
        checks++; if (h !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", h); end
        checks++; if (l !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", l); end
    endtask

    task automatic test_div();
        int lat; logic [31:0] h, l; logic bz;
        @(posedge clk); #1;
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, h, l, bz);
        checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL div_latency got %0d exp %0d", lat, DIV_LAT); end
        checks++; if (l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", l); end
        checks++; if (h !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", h); end
        @(posedge clk); #1;
        run_op(2'b11, 32'd7, 32'd2, lat, h, l, bz);
        checks++; if (l !== 32'd3) begin errors++; $display("FAIL divu_lo got %h exp 3", l); end
        checks++; if (h !== 32'd1) begin errors++; $display("FAIL divu_hi got %h exp 1", h); end
        @(posedge clk); #1;
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, h, l, bz);
        checks++; if (l !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h exp 80000000", l); end
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got %h exp 0", h); end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] h, l; logic bz;
        @(posedge clk); #1;
        run_op(2'b11, 32'd5, 32'd0, lat, h, l, bz);
        checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL divz_latency got %0d exp %0d", lat, DIV_LAT); end
        checks++; if (h !== 32'd5) begin errors++; $display("FAIL divuz_hi got %h exp 5", h); end
        checks++; if (l !== 32'hFFFFFFFF) begin errors++; $display("FAIL divuz_lo got %h exp ffffffff", l); end
        @(posedge clk); #1;
        run_op(2'b10, 32'hFFFFFFFB, 32'd0, lat, h, l, bz);
        checks++; if (h !== 32'hFFFFFFFB) begin errors++; $display("FAIL divz_hi got %h exp fffffffb", h); end
        checks++; if (l !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo got %h exp ffffffff", l); end
    endtask

    task automatic test_mthi_mtlo();
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h exp 1234", hi); end
        lo_we = 1'b1; wdata = 32'h5678;
        @(posedge clk); #1;
        lo_we = 1'b0;
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo got %h exp 5678", lo); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_keeps_hi got %h exp 1234", hi); end
    endtask

    task automatic test_start_wins();
        int n;
        start = 1'b1; op = 2'b01; rs_data = 32'd2; rt_data = 32'd3;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL start_wins_hi got %h exp 1234", hi); end
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL start_wins_lo got %h exp 5678", lo); end
        n = 1;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (lo !== 32'd6 || hi !== 32'd0) begin errors++; $display("FAIL start_wins_result got %h_%h exp 0_6", hi, lo); end
    endtask

    task automatic test_write_busy();
        int n;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        repeat (5) begin @(posedge clk); #1; end
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL busy_write_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL busy_write_lo got %h exp 6", lo); end
        n = 6;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (hi !== 32'd0 || lo !== 32'd15) begin errors++; $display("FAIL busy_write_result got %h_%h exp 0_f", hi, lo); end
    endtask

    task automatic test_start_busy();
        int n, pulses;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; rs_data = 32'd7; rt_data = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        repeat (5) begin @(posedge clk); #1; n++; end
        start = 1'b1; op = 2'b01; rs_data = 32'd100; rt_data = 32'd10;
        @(posedge clk); #1;
        start = 1'b0; n++;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (n !== DIV_LAT) begin errors++; $display("FAIL start_busy_latency got %0d exp %0d", n, DIV_LAT); end
        checks++; if (lo !== 32'd3 || hi !== 32'd1) begin errors++; $display("FAIL start_busy_result got %h_%h exp 1_3", hi, lo); end
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL start_busy_extra_done got %0d exp 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] h, l; logic bz;
        @(posedge clk); #1;
        run_op(2'b11, 32'd100, 32'd7, lat, h, l, bz);
        checks++; if (l !== 32'd14 || h !== 32'd2) begin errors++; $display("FAIL b2b_first got %h_%h exp 2_e", h, l); end
        run_op(2'b10, 32'd100, 32'hFFFFFFF9, lat, h, l, bz);
        checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, DIV_LAT); end
        checks++; if (l !== 32'hFFFFFFF2 || h !== 32'd2) begin errors++; $display("FAIL b2b_second got %h_%h exp 2_fffffff2", h, l); end
    endtask

    task automatic test_reset_midrun();
        int pulses;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; rs_data = 32'd7; rt_data = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL midrst_hilo got %h_%h exp 0_0", hi, lo); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (done) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_done got %0d exp 0", pulses); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b exp 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00;
        rs_data = '0; rt_data = '0; wdata = '0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_start_wins();
        test_write_busy();
        test_start_busy();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the Mini-MIPS datapath, sitting directly downstream of the register file read ports. It takes the two operands read for rs and rt and runs MULT/MULTU/DIV/DIVU iteratively. Results go into architectural HI/LO registers, which later MFHI/MFLO paths read. A busy/done handshake lets the control unit stall dependent instructions.

## Interface
Parameters:
- D, 32, operand and HI/LO data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation, sampled only when idle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  D  operand A / dividend (register file read port 1)
- rt_data  in  D  operand B / divisor (register file read port 2)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  D  MTHI/MTLO data (rs value)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  D  HI register
- lo  out  D  LO register

## Operation
- States: IDLE, RUN, FIX.
  - IDLE→RUN on start: latches op and operands. Signed ops latch magnitudes plus result-sign flags.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. A 6-bit counter runs 0..D-1. After the step at count D-1, go to FIX.
  - FIX: apply the sign correction and write HI/LO. Assert done for one cycle, then return to IDLE.
- Multiply: {HI,LO} = full 2D-bit product. MULT is signed two's complement; MULTU is unsigned.
- Divide: LO = quotient, HI = remainder.
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - DIV of 0x80000000 by -1 gives LO=0x80000000, HI=0.
- Divide by zero (rt_data=0): no trap. HI = rs_data, LO = all ones.
  - Takes the same latency as a normal divide.
  - Applies to both signed and unsigned divide.
- MTHI/MTLO: when idle, hi_we/lo_we write wdata on the clock edge.
- Writes while busy are ignored.
- If start and hi_we/lo_we are asserted in the same idle cycle, start wins and the writes are dropped.
- start while busy is ignored. No queueing.
- Reset (any state): IDLE, counter 0, hi=0, lo=0, busy=0, done=0. A mid-operation reset discards the result.

## Timing
- Edge 0 samples start. RUN occupies edges 1..D. FIX is edge D+1.
- hi/lo are updated at edge D+1.
- done is high in the cycle after edge D+1, which is 34 cycles after start for D=32.
- busy is high from the cycle after edge 0 through FIX. busy is low in the cycle where done is high.
- done comes from a register. hi/lo come from registers with no combinational path from inputs.
- A new start is accepted in the same cycle as done, so back-to-back operations are possible.

## Configuration
- MULDIV_FAST_MUL_EN defined: MULT/MULTU use a single-cycle combinational multiplier. The path is IDLE→FIX and skips RUN, so done is high 2 cycles after start. Division is unchanged.
- Undefined: all ops are iterative with the latency above.

## Structure
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum (IDLE, RUN, FIX)
  - divide-by-zero LO constant
- Sub-module muldiv_step: the combinational single-iteration datapath (shift-add or restoring subtract on accumulator/remainder plus quotient). It is instantiated once.
- Top level holds the FSM, counter, sign fixup and HI/LO registers.

## Test plan
- MULT rs=-3 (0xFFFFFFFD), rt=7:
  - done exactly 34 cycles after start.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - busy low on done.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=-7, rt=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU rs=7, rt=2 → LO=3, HI=1.
- DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU rs=5, rt=0 → HI=5, LO=0xFFFFFFFF.
- MTHI 0x1234 while idle → hi=0x1234 next cycle.
- hi_we while busy → hi unchanged.
- start while busy ignored, with the original result intact.
- rst_n pulsed low at RUN cycle 10 → immediately busy=0, hi=lo=0, and no done follows.
- Under MULDIV_FAST_MUL_EN, MULT 6×7 → done 2 cycles after start, LO=42, HI=0.
